credit_rr_allocator: RTL and testbench

Credit-based round-robin allocator for one router output port in the flattened-butterfly NoC. It arbitrates among the INPORT input FIFOs requesting the port. It tracks free slots in the downstream input FIFO with a credit counter, so no flit is launched into a full buffer. It also exposes a saturating stall counter for throughput debug. One instance sits per output port, between the route_compute request vectors and the xbar select lines.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/credit_rr_allocator_rr_pick.sv | 37 +++
 rtl/credit_rr_allocator.sv | 99 +++++++++
 tb/tb_credit_rr_allocator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC-wide defaults and width helpers.
//   NOC_INPORT   - default requester count per output port (local port included)
//   NOC_CREDITS  - default downstream FIFO depth
//   NOC_STALL_W  - default width of debug stall counters
//   cred_width() - bits needed to hold a credit count of 0..n
//   idx_width()  - bits needed to index n requesters (min 1)
package noc_pkg;

  localparam int NOC_INPORT  = 7;
  localparam int NOC_CREDITS = 8;
  localparam int NOC_STALL_W = 16;

  function automatic int cred_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/credit_rr_allocator_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Scans req starting at ptr, wrapping mod N, and grants the first set bit.
//   req  in  [0:N-1]   request vector
//   ptr  in  [PW-1:0]  index with highest priority this cycle (0..N-1)
//   en   in  1         grant enable; when low gnt is zero
//   gnt  out [0:N-1]   one-hot grant or zero
//   idx  out [PW-1:0]  encoded index of the granted requester (0 if none)
module rr_pick #(
  parameter int N  = 7,
  parameter int PW = 3
) (
  input  logic [0:N-1]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [0:N-1]  gnt,
  output logic [PW-1:0] idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (int'(unsigned'(ptr)) + off) % N;
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/credit_rr_allocator.sv
// credit_rr_allocator: credit-based round-robin allocator for one router
// output port. Grants one requesting input FIFO per cycle while downstream
// credits remain, tracks free downstream slots, flags credit overflow and
// counts credit-starved cycles.
//
// Optional build macro: CRALLOC_CREDIT_BYPASS_EN
//   defined   - a credit returned this cycle may enable a grant at
//               credit_count==0 (combinational credit_return -> grants_out)
//   undefined - grant enable depends only on the registered credit_count
//
// Ports:
//   clk           in  1             system clock
//   rst           in  1             synchronous active-high reset
//   requests      in  [0:INPORT-1]  bit i: input i has a head flit for this port
//   off_sig       in  1             external stall, blocks all grants
//   credit_return in  1             one downstream slot freed this cycle
//   grants_out    out [0:INPORT-1]  one-hot or zero grant (FIFO rd_en, xbar sel)
//   valid_o       out 1             flit launched this cycle
//   credit_count  out [CRED_W-1:0]  registered free-slot count
//   credit_err    out 1             sticky credit-overflow flag
//   stall_cnt     out [STALL_W-1:0] saturating credit-starved cycle count
module credit_rr_allocator
  import noc_pkg::*;
#(
  parameter  int INPORT  = NOC_INPORT,
  parameter  int CREDITS = NOC_CREDITS,
  parameter  int STALL_W = NOC_STALL_W,
  localparam int CRED_W  = cred_width(CREDITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:INPORT-1]   requests,
  input  logic                off_sig,
  input  logic                credit_return,
  output logic [0:INPORT-1]   grants_out,
  output logic                valid_o,
  output logic [CRED_W-1:0]   credit_count,
  output logic                credit_err,
  output logic [STALL_W-1:0]  stall_cnt
);

  localparam int PTR_W = idx_width(INPORT);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             cred_avail;
  logic             en;

  always_comb begin
`ifdef CRALLOC_CREDIT_BYPASS_EN
    cred_avail = (credit_count != '0) || credit_return;
`else
    cred_avail = (credit_count != '0);
`endif
    // Gating with rst keeps grants (and FIFO reads) off during the reset cycle.
    en = !rst && !off_sig && cred_avail;
  end

  rr_pick #(
    .N  (INPORT),
    .PW (PTR_W)
  ) u_pick (
    .req (requests),
    .ptr (ptr),
    .en  (en),
    .gnt (grants_out),
    .idx (gnt_idx)
  );

  assign valid_o = |grants_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      credit_count <= CRED_W'(CREDITS);
      credit_err   <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (valid_o)
        ptr <= (gnt_idx == PTR_W'(INPORT - 1)) ? '0 : gnt_idx + PTR_W'(1);

      // Grant and return together leave the count unchanged; this also covers
      // a bypass grant at zero credits, which must keep the count at 0.
      if (valid_o && !credit_return) begin
        credit_count <= credit_count - CRED_W'(1);
      end else if (!valid_o && credit_return) begin
        if (credit_count == CRED_W'(CREDITS))
          credit_err <= 1'b1;
        else
          credit_count <= credit_count + CRED_W'(1);
      end

      if ((|requests) && !off_sig && (credit_count == '0) && !valid_o &&
          (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_credit_rr_allocator.sv
module tb_credit_rr_allocator;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:N-1] requests;
  logic         off_sig;
  logic         credit_return;
  logic [0:N-1] grants_out;
  logic         valid_o;
  logic [3:0]   credit_count;
  logic         credit_err;
  logic [15:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall;

  credit_rr_allocator #(
    .INPORT  (7),
    .CREDITS (8),
    .STALL_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .requests      (requests),
    .off_sig       (off_sig),
    .credit_return (credit_return),
    .grants_out    (grants_out),
    .valid_o       (valid_o),
    .credit_count  (credit_count),
    .credit_err    (credit_err),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [0:N-1] oh(input int k);
    logic [0:N-1] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; requests = '1; off_sig = 1'b0; credit_return = 1'b0;
    #1;
    // rst cycle: no grants even with all requests pending
    chk("rst_grants", 32'(grants_out), 0);
    chk("rst_valid", 32'(valid_o), 0);
    cyc();
    rst = 1'b0; requests = '0;
    #1;
    chk("reset_credit", 32'(credit_count), 8);
    chk("reset_err", 32'(credit_err), 0);
    chk("reset_stall", 32'(stall_cnt), 0);

    // 8 grants 0..6,0 exhaust credits
    requests = 7'b1111111;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("rr_grant", 32'(grants_out), 32'(oh(j % 7)));
      chk("rr_credit", 32'(credit_count), 32'(8 - j));
      cyc();
    end
    // starved: no grants, stall counts up
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("starve_credit", 32'(credit_count), 0);
      chk("starve_grant", 32'(grants_out), 0);
      chk("starve_stall", 32'(stall_cnt), 32'(j));
      cyc();
    end
    exp_stall = 3;   // ptr now 1

    // credit return pulse with only input 2 requesting
    requests = 7'b0010000; credit_return = 1'b1;
    #1;
`ifdef CRALLOC_CREDIT_BYPASS_EN
    chk("bypass_grant", 32'(grants_out), 32'(oh(2)));
    cyc();
    credit_return = 1'b0;
    #1;
    chk("bypass_credit", 32'(credit_count), 0);
    chk("bypass_stall", 32'(stall_cnt), 32'(exp_stall));
`else
    chk("ret_nogrant", 32'(grants_out), 0);
    cyc();
    credit_return = 1'b0;
    exp_stall = 4;
    #1;
    chk("ret_credit", 32'(credit_count), 1);
    chk("ret_stall", 32'(stall_cnt), 32'(exp_stall));
    chk("ret_grant", 32'(grants_out), 32'(oh(2)));
    cyc();
    chk("ret_credit_after", 32'(credit_count), 0);
`endif
    // ptr now 3; return 3 credits with no requests
    requests = '0; credit_return = 1'b1;
    for (int j = 0; j < 3; j++) cyc();
    credit_return = 1'b0;
    chk("refill3", 32'(credit_count), 3);

    // off_sig blocks grants, state unchanged
    requests = '1; off_sig = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("off_grant", 32'(grants_out), 0);
      cyc();
    end
    chk("off_credit", 32'(credit_count), 3);
    chk("off_stall", 32'(stall_cnt), 32'(exp_stall));
    off_sig = 1'b0;
    #1;
    chk("off_ptr_held", 32'(grants_out), 32'(oh(3)));
    cyc();
    chk("off_after_credit", 32'(credit_count), 2);

    // refill to 8 (ptr now 4)
    requests = '0; credit_return = 1'b1;
    for (int j = 0; j < 6; j++) cyc();
    chk("refill8", 32'(credit_count), 8);

    // grant + return each cycle, inputs 0 and 6; from ptr 4 first grant is 6
    requests = 7'b1000001;
    for (int j = 0; j < 20; j++) begin
      #1;
      chk("alt_grant", 32'(grants_out), 32'(oh((j % 2 == 0) ? 6 : 0)));
      cyc();
      chk("alt_credit", 32'(credit_count), 8);
    end

    // overflow at full credits (ptr now 1)
    requests = '0; credit_return = 1'b1;
    cyc();
    credit_return = 1'b0;
    chk("ovf_credit", 32'(credit_count), 8);
    chk("ovf_err", 32'(credit_err), 1);
    cyc(); cyc();
    chk("ovf_err_hold", 32'(credit_err), 1);

    // drive to credit_count=3, ptr=4: grants 1,2,3 then 3,3
    requests = '1;
    for (int j = 1; j <= 3; j++) begin
      #1;
      chk("pre_grant", 32'(grants_out), 32'(oh(j)));
      cyc();
    end
    requests = oh(3);
    cyc(); cyc();
    chk("pre_credit", 32'(credit_count), 3);
    chk("pre_err", 32'(credit_err), 1);

    // mid-stream reset
    requests = '1; rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grants_out), 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_credit", 32'(credit_count), 8);
    chk("mid_rst_err", 32'(credit_err), 0);
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    chk("mid_rst_ptr", 32'(grants_out), 32'(oh(0)));
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
